// File: rtl/mips_pkg.sv
// mips_pkg
// Shared constants and types for the MIPS control/execute slice:
//   - primary opcodes (instr[31:26]) that the decoder recognises
//   - R-type funct codes (instr[5:0]) that the decoder maps to ALU operations
//   - 3-bit ALU control codes used by the decoder and by alu32
//   - the packed decode-control bundle and the R-type funct-to-ALU mapping
package mips_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_ZERO = 3'b011;
    localparam logic [2:0] ALU_ANDN = 3'b100;
    localparam logic [2:0] ALU_ORN  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    typedef struct packed {
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src;
        logic       branch;
        logic       mem_write;
        logic       mem_to_reg;
        logic       jump;
        logic [2:0] alu_control;
    } ctrl_t;

    // Unrecognised functs select AND (000); the instruction still writes back.
    function automatic logic [2:0] funct_to_alu(input logic [5:0] funct);
        logic [2:0] alu;
        case (funct)
            FN_ADD:  alu = ALU_ADD;
            FN_SUB:  alu = ALU_SUB;
            FN_AND:  alu = ALU_AND;
            FN_OR:   alu = ALU_OR;
            FN_SLT:  alu = ALU_SLT;
            default: alu = ALU_AND;
        endcase
        return alu;
    endfunction

endpackage

// File: rtl/mips_ctrl_exec_slice_if.sv
// mips_ctrl_exec_slice_if
// Execute-to-memory bus of the slice.
//   master: execute-stage producer (drives operands/store data/controls/flush,
//           observes ALU result and the registered memory-stage fields)
//   slave : the slice (consumes execute-stage fields, returns ALU result and
//           the EX/MEM register contents)
interface mips_ctrl_exec_slice_if;

    logic [31:0] src_a_e;
    logic [31:0] src_b_e;
    logic [2:0]  alu_control_e;
    logic [31:0] alu_out_e;
    logic        zero_e;
    logic        flush_m;
    logic [31:0] write_data_e;
    logic [4:0]  write_reg_e;
    logic        mem_write_e;
    logic        mem_to_reg_e;
    logic        reg_write_e;
    logic [31:0] alu_out_m;
    logic [31:0] write_data_m;
    logic [4:0]  write_reg_m;
    logic        mem_write_m;
    logic        mem_to_reg_m;
    logic        reg_write_m;

    modport master (
        output src_a_e, src_b_e, alu_control_e, flush_m, write_data_e,
               write_reg_e, mem_write_e, mem_to_reg_e, reg_write_e,
        input  alu_out_e, zero_e, alu_out_m, write_data_m, write_reg_m,
               mem_write_m, mem_to_reg_m, reg_write_m
    );

    modport slave (
        input  src_a_e, src_b_e, alu_control_e, flush_m, write_data_e,
               write_reg_e, mem_write_e, mem_to_reg_e, reg_write_e,
        output alu_out_e, zero_e, alu_out_m, write_data_m, write_reg_m,
               mem_write_m, mem_to_reg_m, reg_write_m
    );

endinterface

// File: rtl/alu32.sv
// alu32
// Combinational 32-bit execute-stage ALU. Arithmetic wraps modulo 2^32.
//   i_a, i_b : operands
//   i_ctrl   : 3-bit operation select (mips_pkg ALU_* codes)
//   o_y      : result
//   o_zero   : high when o_y == 0
module alu32
    import mips_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [2:0]  i_ctrl,
    output logic [31:0] o_y,
    output logic        o_zero
);

    always_comb begin
        o_y = 32'd0;
        case (i_ctrl)
            ALU_AND:  o_y = i_a & i_b;
            ALU_OR:   o_y = i_a | i_b;
            ALU_ADD:  o_y = i_a + i_b;
            ALU_SUB:  o_y = i_a - i_b;
            ALU_SLT:  o_y = {31'd0, ($signed(i_a) < $signed(i_b))};
            ALU_ANDN: o_y = i_a & ~i_b;
            ALU_ORN:  o_y = i_a | ~i_b;
            ALU_ZERO: o_y = 32'd0;
            default:  o_y = 32'd0;
        endcase
    end

    assign o_zero = (o_y == 32'd0);

endmodule

// File: rtl/mips_ctrl_exec_slice.sv
// mips_ctrl_exec_slice
// Decode-stage main/ALU-control decoder, execute-stage ALU and EX/MEM register.
//   clk, reset                : clock, synchronous active-high reset of EX/MEM
//   opcode_d, funct_d, eq_d   : decode-stage instruction fields and Rs==Rt flag
//   *_d outputs               : decode control bundle (combinational)
//   ex (slave modport)        : execute operands/controls in, ALU result and
//                               registered memory-stage fields out
module mips_ctrl_exec_slice
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode_d,
    input  logic [5:0] funct_d,
    input  logic       eq_d,
    output logic       mem_to_reg_d,
    output logic       mem_write_d,
    output logic       pc_src_d,
    output logic       alu_src_d,
    output logic       reg_dst_d,
    output logic       reg_write_d,
    output logic       branch_d,
    output logic       jump_d,
    output logic [2:0] alu_control_d,
    mips_ctrl_exec_slice_if.slave ex
);

    ctrl_t w_ctrl;

    always_comb begin
        w_ctrl = '0;
        case (opcode_d)
            OP_R: begin
                w_ctrl.reg_write   = 1'b1;
                w_ctrl.reg_dst     = 1'b1;
                w_ctrl.alu_control = funct_to_alu(funct_d);
            end
            OP_LW: begin
                w_ctrl.reg_write   = 1'b1;
                w_ctrl.alu_src     = 1'b1;
                w_ctrl.mem_to_reg  = 1'b1;
                w_ctrl.alu_control = ALU_ADD;
            end
            OP_SW: begin
                w_ctrl.alu_src     = 1'b1;
                w_ctrl.mem_write   = 1'b1;
                w_ctrl.alu_control = ALU_ADD;
            end
            OP_BEQ: begin
                w_ctrl.branch      = 1'b1;
                w_ctrl.alu_control = ALU_SUB;
            end
            OP_ADDI: begin
                w_ctrl.reg_write   = 1'b1;
                w_ctrl.alu_src     = 1'b1;
                w_ctrl.alu_control = ALU_ADD;
            end
            OP_J: begin
                w_ctrl.jump        = 1'b1;
                w_ctrl.alu_control = ALU_ADD;
            end
            default: w_ctrl = '0;
        endcase
    end

    assign reg_write_d   = w_ctrl.reg_write;
    assign reg_dst_d     = w_ctrl.reg_dst;
    assign alu_src_d     = w_ctrl.alu_src;
    assign branch_d      = w_ctrl.branch;
    assign mem_write_d   = w_ctrl.mem_write;
    assign mem_to_reg_d  = w_ctrl.mem_to_reg;
    assign jump_d        = w_ctrl.jump;
    assign alu_control_d = w_ctrl.alu_control;
    assign pc_src_d      = w_ctrl.branch & eq_d;

    logic [31:0] w_alu_out;
    logic        w_zero;

    alu32 u_alu (
        .i_a    (ex.src_a_e),
        .i_b    (ex.src_b_e),
        .i_ctrl (ex.alu_control_e),
        .o_y    (w_alu_out),
        .o_zero (w_zero)
    );

    assign ex.alu_out_e = w_alu_out;
    assign ex.zero_e    = w_zero;

    // EX/MEM register: no enable. Flush inserts a bubble exactly like reset,
    // clearing the write enables so nothing downstream commits.
    logic [31:0] r_alu_out_m;
    logic [31:0] r_write_data_m;
    logic [4:0]  r_write_reg_m;
    logic        r_mem_write_m;
    logic        r_mem_to_reg_m;
    logic        r_reg_write_m;

    always_ff @(posedge clk) begin
        if (reset || ex.flush_m) begin
            r_alu_out_m    <= 32'd0;
            r_write_data_m <= 32'd0;
            r_write_reg_m  <= 5'd0;
            r_mem_write_m  <= 1'b0;
            r_mem_to_reg_m <= 1'b0;
            r_reg_write_m  <= 1'b0;
        end else begin
            r_alu_out_m    <= w_alu_out;
            r_write_data_m <= ex.write_data_e;
            r_write_reg_m  <= ex.write_reg_e;
            r_mem_write_m  <= ex.mem_write_e;
            r_mem_to_reg_m <= ex.mem_to_reg_e;
            r_reg_write_m  <= ex.reg_write_e;
        end
    end

    assign ex.alu_out_m    = r_alu_out_m;
    assign ex.write_data_m = r_write_data_m;
    assign ex.write_reg_m  = r_write_reg_m;
    assign ex.mem_write_m  = r_mem_write_m;
    assign ex.mem_to_reg_m = r_mem_to_reg_m;
    assign ex.reg_write_m  = r_reg_write_m;

endmodule

// File: tb/tb_mips_ctrl_exec_slice.sv
// tb_mips_ctrl_exec_slice
// Directed bench: decoder sweep, ALU table, and an EX/MEM scoreboard where the
// expected register contents are queued when inputs are driven and popped
// after the capturing edge.
module tb_mips_ctrl_exec_slice;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode_d;
    logic [5:0] funct_d;
    logic       eq_d;
    logic       mem_to_reg_d, mem_write_d, pc_src_d, alu_src_d;
    logic       reg_dst_d, reg_write_d, branch_d, jump_d;
    logic [2:0] alu_control_d;

    mips_ctrl_exec_slice_if u_if ();

    mips_ctrl_exec_slice dut (
        .clk           (clk),
        .reset         (reset),
        .opcode_d      (opcode_d),
        .funct_d       (funct_d),
        .eq_d          (eq_d),
        .mem_to_reg_d  (mem_to_reg_d),
        .mem_write_d   (mem_write_d),
        .pc_src_d      (pc_src_d),
        .alu_src_d     (alu_src_d),
        .reg_dst_d     (reg_dst_d),
        .reg_write_d   (reg_write_d),
        .branch_d      (branch_d),
        .jump_d        (jump_d),
        .alu_control_d (alu_control_d),
        .ex            (u_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] write_data;
        logic [4:0]  write_reg;
        logic        mem_write;
        logic        mem_to_reg;
        logic        reg_write;
    } exmem_t;

    exmem_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Order: reg_write, reg_dst, alu_src, branch, mem_write, mem_to_reg, jump, pc_src, alu_control
    function automatic logic [10:0] dec_vec();
        return {reg_write_d, reg_dst_d, alu_src_d, branch_d, mem_write_d,
                mem_to_reg_d, jump_d, pc_src_d, alu_control_d};
    endfunction

    task automatic decode(input string tag, input logic [5:0] op, input logic [5:0] fn,
                          input logic eq, input logic [10:0] exp);
        opcode_d = op;
        funct_d  = fn;
        eq_d     = eq;
        #1;
        check(tag, {21'd0, dec_vec()}, {21'd0, exp});
        $display("dec %s op=%b fn=%b eq=%b ctrl=%b", tag, op, fn, eq, dec_vec());
    endtask

    task automatic drive_ex(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c,
                            input logic [31:0] wd, input logic [4:0] wr,
                            input logic mw, input logic mtr, input logic rw);
        u_if.src_a_e       = a;
        u_if.src_b_e       = b;
        u_if.alu_control_e = c;
        u_if.write_data_e  = wd;
        u_if.write_reg_e   = wr;
        u_if.mem_write_e   = mw;
        u_if.mem_to_reg_e  = mtr;
        u_if.reg_write_e   = rw;
    endtask

    task automatic push_exp(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                            input logic mw, input logic mtr, input logic rw);
        exmem_t e;
        e.alu_out    = alu;
        e.write_data = wd;
        e.write_reg  = wr;
        e.mem_write  = mw;
        e.mem_to_reg = mtr;
        e.reg_write  = rw;
        sb.push_back(e);
    endtask

    // Advance one edge, then compare the memory-stage fields with the oldest
    // queued expectation.
    task automatic tick(input string tag);
        exmem_t e;
        @(posedge clk);
        #1;
        checks++;
        assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_alu_out_m"},    u_if.alu_out_m,    e.alu_out);
            check({tag, "_write_data_m"}, u_if.write_data_m, e.write_data);
            check({tag, "_write_reg_m"},  {27'd0, u_if.write_reg_m}, {27'd0, e.write_reg});
            check({tag, "_ctrl_m"},
                  {29'd0, u_if.mem_write_m, u_if.mem_to_reg_m, u_if.reg_write_m},
                  {29'd0, e.mem_write, e.mem_to_reg, e.reg_write});
        end
        $display("exmem %s alu=%h wd=%h wr=%0d mw=%b mtr=%b rw=%b", tag, u_if.alu_out_m,
                 u_if.write_data_m, u_if.write_reg_m, u_if.mem_write_m,
                 u_if.mem_to_reg_m, u_if.reg_write_m);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] alu_a   [11];
        logic [31:0] alu_b   [11];
        logic [2:0]  alu_c   [11];
        logic [31:0] alu_y   [11];
        logic        alu_z   [11];

        reset        = 1'b1;
        opcode_d     = 6'd0;
        funct_d      = 6'd0;
        eq_d         = 1'b0;
        u_if.flush_m = 1'b0;

        // Reset held for two edges with nonzero inputs: bubbles only.
        drive_ex(32'd5, 32'd7, 3'b010, 32'h0000_00AA, 5'd9, 1'b1, 1'b1, 1'b1);
        push_exp(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick("rst0");
        push_exp(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick("rst1");

        // Combinational ALU output is live while reset is held.
        check("alu_during_reset", u_if.alu_out_e, 32'd12);

        // Release reset: captured after the next edge.
        reset = 1'b0;
        drive_ex(32'd5, 32'd7, 3'b010, 32'h0000_00AA, 5'd9, 1'b0, 1'b0, 1'b1);
        push_exp(32'd12, 32'h0000_00AA, 5'd9, 1'b0, 1'b0, 1'b1);
        tick("cap0");

        // New inputs do not reach _m before the edge.
        drive_ex(32'h10, 32'd3, 3'b110, 32'hDEAD_BEEF, 5'd31, 1'b1, 1'b0, 1'b0);
        #1;
        check("hold_before_edge", u_if.alu_out_m, 32'd12);
        push_exp(32'd13, 32'hDEAD_BEEF, 5'd31, 1'b1, 1'b0, 1'b0);
        tick("cap1");

        // Flush inserts a bubble.
        u_if.flush_m = 1'b1;
        drive_ex(32'd1, 32'd2, 3'b010, 32'h1234_5678, 5'd4, 1'b1, 1'b1, 1'b1);
        push_exp(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick("flush");
        u_if.flush_m = 1'b0;
        push_exp(32'd3, 32'h1234_5678, 5'd4, 1'b1, 1'b1, 1'b1);
        tick("after_flush");

        // Reset mid-stream acts at the next edge only.
        reset = 1'b1;
        drive_ex(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b000, 32'h5, 5'd7, 1'b1, 1'b0, 1'b1);
        #1;
        check("midrst_hold", u_if.alu_out_m, 32'd3);
        check("midrst_alu_live", u_if.alu_out_e, 32'h00F0_00F0);
        push_exp(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick("midrst");
        reset = 1'b0;
        push_exp(32'h00F0_00F0, 32'h5, 5'd7, 1'b1, 1'b0, 1'b1);
        tick("after_midrst");

        // Decoder sweep.
        decode("lw",     6'b100011, 6'b000000, 1'b1, 11'b10100100_010);
        decode("sw",     6'b101011, 6'b000000, 1'b0, 11'b00101000_010);
        decode("j",      6'b000010, 6'b000000, 1'b1, 11'b00000010_010);
        decode("bad_op", 6'b111111, 6'b100000, 1'b1, 11'b00000000_000);
        decode("addi",   6'b001000, 6'b000000, 1'b0, 11'b10100000_010);
        decode("beq_eq", 6'b000100, 6'b000000, 1'b1, 11'b00010001_110);
        decode("beq_ne", 6'b000100, 6'b000000, 1'b0, 11'b00010000_110);
        decode("r_add",  6'b000000, 6'b100000, 1'b0, 11'b11000000_010);
        decode("r_sub",  6'b000000, 6'b100010, 1'b0, 11'b11000000_110);
        decode("r_and",  6'b000000, 6'b100100, 1'b0, 11'b11000000_000);
        decode("r_or",   6'b000000, 6'b100101, 1'b0, 11'b11000000_001);
        decode("r_slt",  6'b000000, 6'b101010, 1'b1, 11'b11000000_111);
        decode("r_bad",  6'b000000, 6'b111111, 1'b0, 11'b11000000_000);

        // ALU table: a, b, ctrl, result, zero.
        alu_a = '{32'd5, 32'd0, 32'd3, 32'hFFFF_FFFF, 32'd1, 32'hF0F0_F0F0,
                  32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'd0, 32'd5, 32'hFFFF_FFFF};
        alu_b = '{32'd7, 32'd1, 32'd3, 32'd1, 32'hFFFF_FFFF, 32'h0FF0_0FF0,
                  32'h0F0F_0000, 32'h0FF0_0FF0, 32'hFFFF_0000, 32'd7, 32'd2};
        alu_c = '{3'b010, 3'b110, 3'b110, 3'b111, 3'b111, 3'b000,
                  3'b001, 3'b100, 3'b101, 3'b011, 3'b010};
        alu_y = '{32'd12, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0, 32'h00F0_00F0,
                  32'hFFFF_F0F0, 32'hF000_F000, 32'h0000_FFFF, 32'd0, 32'd1};
        alu_z = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 11; i++) begin
            u_if.src_a_e       = alu_a[i];
            u_if.src_b_e       = alu_b[i];
            u_if.alu_control_e = alu_c[i];
            #1;
            check($sformatf("alu%0d_y", i), u_if.alu_out_e, alu_y[i]);
            check($sformatf("alu%0d_zero", i), {31'd0, u_if.zero_e}, {31'd0, alu_z[i]});
            $display("alu %0d a=%h b=%h c=%b y=%h z=%b", i, alu_a[i], alu_b[i], alu_c[i],
                     u_if.alu_out_e, u_if.zero_e);
        end

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL sb_drain observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
